// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_unit
//  Description : Instruction fetch/decode sequencer. Walks a ROM program from
//                address 0 and issues decoded opcode/ra/rb fields to an
//                execute stage through a valid/ready handshake. Stops on an
//                "out" opcode, on an undefined opcode, or at the top of the
//                8-bit address space.
//  Options     : FDU_INSTR_COUNT_EN - adds the issued_count output, an
//                8-bit saturating count of handshakes since the last start.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] prog_sel,
  output logic [1:0] prog,
  output logic [7:0] address,
  input  logic [7:0] instruction,
  output logic [3:0] opcode,
  output logic [1:0] ra,
  output logic [1:0] rb,
  output logic       instr_valid,
  input  logic       instr_ready,
`ifdef FDU_INSTR_COUNT_EN
  output logic [7:0] issued_count,
`endif
  output logic       busy,
  output logic       done,
  output logic       fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_OUT   = 4'b1011;
  localparam logic [7:0] ADDR_MAX = 8'hFF;

  state_t     state_q, state_d;
  logic [1:0] prog_q,  prog_d;
  logic [7:0] addr_q,  addr_d;
  logic [7:0] ir_q,    ir_d;
  logic       fault_q, fault_d;

  logic       handshake;
  logic       op_undef;

  assign handshake = (state_q == S_ISSUE) && instr_ready;
  // Opcodes 4'b1110 and 4'b1111 are unassigned.
  assign op_undef  = (ir_q[7:5] == 3'b111);

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prog_q  <= 2'd0;
      addr_q  <= 8'd0;
      ir_q    <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: one FETCH cycle, then ISSUE until the handshake.
  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          prog_d  = prog_sel;
          addr_d  = 8'd0;
          fault_d = 1'b0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = instruction;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          if (ir_q[7:4] == OP_OUT) begin
            fault_d = 1'b0;
            state_d = S_DONE;
          end else if (op_undef || (addr_q == ADDR_MAX)) begin
            // Undefined opcode or running off the end of the ROM.
            fault_d = 1'b1;
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FDU_INSTR_COUNT_EN
  logic [7:0] count_q, count_d;

  // Handshake counter, cleared on each accepted start, saturating at 8'hFF.
  always_comb begin
    count_d = count_q;
    if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
      count_d = 8'd0;
    end else if (handshake && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign issued_count = count_q;
`endif

  assign prog        = prog_q;
  assign address     = addr_q;
  assign opcode      = ir_q[7:4];
  assign ra          = ir_q[3:2];
  assign rb          = ir_q[1:0];
  assign instr_valid = (state_q == S_ISSUE);
  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign done        = (state_q == S_DONE);
  assign fault       = fault_q;

endmodule
`default_nettype wire
